// File: rtl/inst_checker_pkg.sv
// Shared definitions for the instruction checkpoint checker: run-control
// state encoding and the default datapath/table sizes.
package inst_checker_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int NUM_TEST_DEF  = 58;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/inst_checker_chk_table.sv
// Checkpoint table: one write port, one asynchronous read port.
// Each entry packs {num_inst, ans}. Contents are not reset.
module chk_table
  import inst_checker_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int NUM_TEST  = NUM_TEST_DEF,
  parameter int IDX_W     = 6
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [IDX_W-1:0]       waddr,
  input  logic [2*WORD_SIZE-1:0] wdata,
  input  logic [IDX_W-1:0]       raddr,
  output logic [2*WORD_SIZE-1:0] rdata
);

  logic [2*WORD_SIZE-1:0] mem_q [NUM_TEST];

  // Store one entry per write strobe; the caller keeps waddr in range.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_checker.sv
// Instruction checkpoint checker: walks a table of (instruction count,
// expected output) pairs while the CPU runs and tallies pass / fail /
// no-result per entry, stopping on halt, timeout, table end or first fail.
module inst_checker
  import inst_checker_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int NUM_TEST     = NUM_TEST_DEF,
  parameter int IDX_W        = 6,
  parameter int MAX_CYCLES   = 20000,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [WORD_SIZE-1:0] cfg_num_inst,
  input  logic [WORD_SIZE-1:0] cfg_ans,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] num_inst,
  input  logic [WORD_SIZE-1:0] output_port,
  input  logic                 is_halted,
  output logic                 busy,
  output logic                 done,
  output logic                 all_pass,
  output logic                 timeout,
  output logic [IDX_W:0]       pass_cnt,
  output logic [IDX_W:0]       fail_cnt,
  output logic [IDX_W:0]       nores_cnt,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic [WORD_SIZE-1:0] first_fail_val,
  output logic [15:0]          cycle_cnt
);

  localparam logic [IDX_W:0] NUM_TEST_C = (IDX_W+1)'(NUM_TEST);
  localparam logic [IDX_W:0] ONE_C      = (IDX_W+1)'(1);
  localparam logic [15:0]    LAST_CYC_C = 16'(MAX_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [IDX_W:0]         ptr_q, ptr_d;
  logic [IDX_W:0]         pass_q, pass_d;
  logic [IDX_W:0]         fail_q, fail_d;
  logic [IDX_W:0]         nores_q, nores_d;
  logic [IDX_W-1:0]       ff_idx_q, ff_idx_d;
  logic [WORD_SIZE-1:0]   ff_val_q, ff_val_d;
  logic [15:0]            cyc_q, cyc_d;
  logic                   timeout_q, timeout_d;

  logic                   tab_we;
  logic                   end_tab;
  logic                   stop_pend;
  logic                   last_cyc;
  logic [IDX_W-1:0]       rd_idx;
  logic [2*WORD_SIZE-1:0] rd_entry;
  logic [WORD_SIZE-1:0]   ent_num;
  logic [WORD_SIZE-1:0]   ent_ans;

  // The table is frozen while a run is walking it.
  assign tab_we    = cfg_we && (state_q != ST_RUN) && ({1'b0, cfg_idx} < NUM_TEST_C);
  assign end_tab   = (ptr_q >= NUM_TEST_C);
  assign rd_idx    = end_tab ? '0 : ptr_q[IDX_W-1:0];
  assign stop_pend = (STOP_ON_FAIL != 0) && (fail_q != '0);
  assign last_cyc  = (cyc_q == LAST_CYC_C);
  assign {ent_num, ent_ans} = rd_entry;

  chk_table #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_TEST  (NUM_TEST),
    .IDX_W     (IDX_W)
  ) u_chk_table (
    .clk   (clk),
    .we    (tab_we),
    .waddr (cfg_idx),
    .wdata ({cfg_num_inst, cfg_ans}),
    .raddr (rd_idx),
    .rdata (rd_entry)
  );

  // Next-state and tally update: at most one entry resolves per RUN clock.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    nores_d   = nores_q;
    ff_idx_d  = ff_idx_q;
    ff_val_d  = ff_val_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          ptr_d     = '0;
          pass_d    = '0;
          fail_d    = '0;
          nores_d   = '0;
          ff_idx_d  = '0;
          ff_val_d  = '0;
          cyc_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_q + 16'd1;
        if (stop_pend || end_tab) begin
          // Previous clock exhausted the table or hit the first fail.
          state_d = ST_DONE;
        end else begin
          if (num_inst == ent_num) begin
            ptr_d = ptr_q + ONE_C;
            if (output_port == ent_ans) begin
              pass_d = pass_q + ONE_C;
            end else begin
              fail_d = fail_q + ONE_C;
              if (fail_q == '0) begin
                ff_idx_d = ptr_q[IDX_W-1:0];
                ff_val_d = output_port;
              end
            end
          end else if (num_inst > ent_num) begin
            // CPU ran past this checkpoint without stopping on it.
            ptr_d   = ptr_q + ONE_C;
            nores_d = nores_q + ONE_C;
          end
          if (is_halted || last_cyc) begin
            state_d = ST_DONE;
          end
          if (last_cyc) begin
            timeout_d = 1'b1;
          end
        end
        // Whatever is still unresolved at the end counts as no-result.
        if (state_d == ST_DONE) begin
          nores_d = NUM_TEST_C - pass_d - fail_d;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and tally registers; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      nores_q   <= '0;
      ff_idx_q  <= '0;
      ff_val_q  <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      nores_q   <= nores_d;
      ff_idx_q  <= ff_idx_d;
      ff_val_q  <= ff_val_d;
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign all_pass       = (state_q == ST_DONE) && (pass_q == NUM_TEST_C);
  assign timeout        = timeout_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign nores_cnt      = nores_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_val = ff_val_q;
  assign cycle_cnt      = cyc_q;

endmodule
